// File: rtl/dmem_ctrl_if.sv
// RAM-side request/grant/response bus of the data-memory controller.
// master = controller, slave = data RAM.
interface dmem_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  o_dm_req;
    logic                  o_dm_we;
    logic [DATA_WIDTH-1:0] o_dm_addr;
    logic [DATA_WIDTH-1:0] o_dm_wdata;
    logic                  i_dm_gnt;
    logic                  i_dm_rvalid;
    logic [DATA_WIDTH-1:0] i_dm_rdata;

    modport master (
        output o_dm_req, o_dm_we, o_dm_addr, o_dm_wdata,
        input  i_dm_gnt, i_dm_rvalid, i_dm_rdata
    );

    modport slave (
        input  o_dm_req, o_dm_we, o_dm_addr, o_dm_wdata,
        output i_dm_gnt, i_dm_rvalid, i_dm_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: one load/store per memory-stage op, sub-word
// stores done as read-modify-write, pipeline stalled until the access retires.
module dmem_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_mem_en,
    input  logic                  i_mem_rd_wr,
    input  logic [DATA_WIDTH-1:0] i_mem_addr,
    input  logic [1:0]            i_byte_off,
    input  logic [1:0]            i_size,
    input  logic [DATA_WIDTH-1:0] i_mem_data_in,
    output logic [DATA_WIDTH-1:0] o_mem_data_out,
    output logic                  o_stall,
    dmem_ctrl_if.master           dm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state;
    logic                  is_store;
    logic [3:0]            mask_q;
    logic [3:0]            mask_next;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        mask_next = 4'b1111;
        case (i_size)
            2'b00:   mask_next = 4'b0001 << i_byte_off;
            2'b01:   mask_next = i_byte_off[1] ? 4'b1100 : 4'b0011;
            default: mask_next = 4'b1111;
        endcase
    end

    // Expand the byte mask to a bit mask, one lane per byte.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        assign bit_mask[8*b +: 8] = {8{mask_q[b]}};
    end

    // o_dm_wdata still holds the lane-positioned store data during RD_WAIT.
    assign merged = (dm.o_dm_wdata & bit_mask) | (dm.i_dm_rdata & ~bit_mask);

    assign o_stall = ((state == IDLE) && i_mem_en) ||
                     (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            is_store       <= 1'b0;
            mask_q         <= 4'b0000;
            o_mem_data_out <= '0;
            dm.o_dm_req    <= 1'b0;
            dm.o_dm_we     <= 1'b0;
            dm.o_dm_addr   <= '0;
            dm.o_dm_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mem_en) begin
                        dm.o_dm_addr  <= i_mem_addr;
                        dm.o_dm_wdata <= i_mem_data_in;
                        is_store      <= i_mem_rd_wr;
                        mask_q        <= mask_next;
                        dm.o_dm_req   <= 1'b1;
                        if (i_mem_rd_wr && i_size[1]) begin
                            dm.o_dm_we <= 1'b1;
                            state      <= WR_REQ;
                        end else begin
                            dm.o_dm_we <= 1'b0;
                            state      <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (dm.i_dm_gnt) begin
                        dm.o_dm_req <= 1'b0;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (dm.i_dm_rvalid) begin
                        if (is_store) begin
                            dm.o_dm_wdata <= merged;
                            dm.o_dm_req   <= 1'b1;
                            dm.o_dm_we    <= 1'b1;
                            state         <= WR_REQ;
                        end else begin
                            o_mem_data_out <= dm.i_dm_rdata;
                            state          <= DONE;
                        end
                    end
                end
                WR_REQ: begin
                    if (dm.i_dm_gnt) begin
                        dm.o_dm_req <= 1'b0;
                        dm.o_dm_we  <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
